// File: rtl/sram_requester.sv
// Bus-master front end for the SDRAM-backed SRAM controller: arbitrates the CPU and
// video ports, turns their level requests into held rd/we strobes, returns ack/err pulses.
module sram_requester #(
  parameter int DROP_WAIT = 4,
  parameter int TIMEOUT   = 255,
  parameter int VID_BURST = 4
) (
  input  logic        clk_sdram,
  input  logic        init,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_din,
  input  logic [1:0]  a_wtbt,
  output logic [15:0] a_dout,
  output logic        a_ack,
  output logic        a_err,
  input  logic        v_req,
  input  logic [23:0] v_addr,
  output logic [15:0] v_dout,
  output logic        v_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready,
  output logic        busy
);
  localparam int VW = $clog2(VID_BURST + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, GAP} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    cnt_next;
  logic [VW-1:0] vid_cnt;
  logic          vid_sel;
  logic          vid_win;
  logic          op_done;
  logic          op_abort;

  // Handshake: a_req/v_req are levels held until that port's ack (or a_err). The
  // controller takes a strobe while ready=1, drops ready while working, and
  // raises it again when the operation is finished.
  always_comb begin
    cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    vid_win  = v_req && !(a_req && vid_cnt == VW'(VID_BURST));
    op_done  = (state == WAIT_HIGH) && mem_ready;
    op_abort = ((state == WAIT_LOW) && mem_ready && cnt == 8'(DROP_WAIT - 1)) ||
               ((state == WAIT_HIGH) && !mem_ready && cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_sdram or posedge init) begin
    if (init) begin
      state    <= IDLE;
      cnt      <= '0;
      vid_cnt  <= '0;
      vid_sel  <= 1'b0;
      a_dout   <= '0;
      a_ack    <= 1'b0;
      a_err    <= 1'b0;
      v_dout   <= '0;
      v_ack    <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wtbt <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      v_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_ready && (a_req || v_req)) begin
            state <= WAIT_LOW;
            cnt   <= '0;
            busy  <= 1'b1;
            if (vid_win) begin
              vid_sel  <= 1'b1;
              vid_cnt  <= a_req ? vid_cnt + 1'b1 : '0;
              mem_addr <= v_addr;
              mem_din  <= '0;
              mem_wtbt <= 2'b11;
              mem_rd   <= 1'b1;
            end else begin
              vid_sel  <= 1'b0;
              vid_cnt  <= '0;
              mem_addr <= a_addr;
              mem_din  <= a_din;
              mem_wtbt <= a_we ? a_wtbt : 2'b11;
              mem_we   <= a_we;
              mem_rd   <= !a_we;
            end
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          cnt <= cnt_next;
          if (op_done || op_abort) begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            state  <= GAP;
            if (op_done) begin
              if (vid_sel) begin
                v_dout <= mem_dout;
                v_ack  <= 1'b1;
              end else begin
                if (!mem_we) a_dout <= mem_dout;
                a_ack <= 1'b1;
              end
            end else if (!vid_sel) begin
              a_err <= 1'b1;
            end
          end else if (state == WAIT_LOW && !mem_ready) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        GAP: begin
          // Strobe stays low here for one cycle so the controller sees the low level.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_requester.sv
// Bench for sram_requester: a reactive controller model, directed scenarios, random
// traffic, and a transaction-level reference checked against the outputs each cycle.
module tb_sram_requester;
  localparam int DROP_WAIT = 4;
  localparam int TIMEOUT   = 255;
  localparam int VID_BURST = 4;

  logic        clk_sdram = 1'b0;
  logic        init = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [23:0] a_addr = '0;
  logic [15:0] a_din = '0;
  logic [1:0]  a_wtbt = '0;
  logic [15:0] a_dout;
  logic        a_ack, a_err;
  logic        v_req = 1'b0;
  logic [23:0] v_addr = '0;
  logic [15:0] v_dout;
  logic        v_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wtbt;
  logic        mem_we, mem_rd;
  logic [15:0] mem_dout = '0;
  logic        mem_ready = 1'b1;
  logic        busy;

  sram_requester #(.DROP_WAIT(DROP_WAIT), .TIMEOUT(TIMEOUT), .VID_BURST(VID_BURST)) dut (
    .clk_sdram(clk_sdram), .init(init),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_wtbt(a_wtbt),
    .a_dout(a_dout), .a_ack(a_ack), .a_err(a_err),
    .v_req(v_req), .v_addr(v_addr), .v_dout(v_dout), .v_ack(v_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk_sdram = ~clk_sdram;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [15:0] e_a_dout, e_v_dout, e_mem_din;
  logic [23:0] e_mem_addr;
  logic [1:0]  e_mem_wtbt;
  logic        e_mem_we, e_mem_rd, e_a_ack, e_a_err, e_v_ack, e_busy;
  bit          model_ok = 0;
  bit          t_open, t_gap, t_vid, t_wr, t_dropped;
  int          t_cycles, vid_run;

  task automatic model_reset();
    {e_a_dout, e_v_dout, e_mem_din, e_mem_addr, e_mem_wtbt} = '0;
    {e_mem_we, e_mem_rd, e_a_ack, e_a_err, e_v_ack, e_busy} = '0;
    t_open = 0; t_gap = 0; t_dropped = 0; t_cycles = 0; vid_run = 0;
    model_ok = 1;
  endtask

  task automatic model_end(input bit ok);
    e_mem_we = 0; e_mem_rd = 0; t_open = 0; t_gap = 1;
    if (ok) begin
      if (t_vid) begin e_v_dout = mem_dout; e_v_ack = 1; end
      else begin
        if (!t_wr) e_a_dout = mem_dout;
        e_a_ack = 1;
      end
    end else if (!t_vid) e_a_err = 1;
  endtask

  task automatic model_step();
    bit vid;
    e_a_ack = 0; e_a_err = 0; e_v_ack = 0;
    if (t_gap) begin
      t_gap = 0; e_busy = 0;
    end else if (t_open) begin
      t_cycles++;
      if (!t_dropped) begin
        if (!mem_ready) begin t_dropped = 1; t_cycles = 0; end
        else if (t_cycles == DROP_WAIT) model_end(0);
      end else if (mem_ready) model_end(1);
      else if (t_cycles == TIMEOUT) model_end(0);
    end else if (mem_ready && (a_req || v_req)) begin
      vid = v_req && !(a_req && vid_run == VID_BURST);
      t_open = 1; t_dropped = 0; t_cycles = 0; t_vid = vid; e_busy = 1;
      if (vid) begin
        vid_run = a_req ? vid_run + 1 : 0;
        e_mem_addr = v_addr; e_mem_din = 0; e_mem_wtbt = 2'b11; e_mem_rd = 1; t_wr = 0;
      end else begin
        vid_run = 0; t_wr = a_we;
        e_mem_addr = a_addr; e_mem_din = a_din; e_mem_wtbt = a_we ? a_wtbt : 2'b11;
        e_mem_we = a_we; e_mem_rd = !a_we;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_sdram or posedge init);
    if (init) model_reset();
    else if (model_ok) model_step();
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial forever begin
    @(negedge clk_sdram);
    if (model_ok) begin
      check("mem_addr", mem_addr, e_mem_addr);
      check("mem_din", mem_din, e_mem_din);
      check("mem_wtbt", mem_wtbt, e_mem_wtbt);
      check("mem_we", mem_we, e_mem_we);
      check("mem_rd", mem_rd, e_mem_rd);
      check("a_dout", a_dout, e_a_dout);
      check("a_ack", a_ack, e_a_ack);
      check("a_err", a_err, e_a_err);
      check("v_dout", v_dout, e_v_dout);
      check("v_ack", v_ack, e_v_ack);
      check("busy", busy, e_busy);
    end
  end

  // ---------------- controller model and driver tasks ----------------
  int          ctl_phase = 0, ctl_left = 0, ctl_cfg_mode = 1, ctl_cfg_hold = 3;
  bit          ctl_release = 0, ctl_data_fixed = 0;
  logic [15:0] ctl_data = '0;
  bit          s_strobe, s_we, s_rd, s_aack, s_aerr, s_vack, s_busy, p_strobe = 0;
  bit          a_hold = 0, v_hold = 0;
  int          rises = 0, cur_len = 0, last_len = 0, we_cycles = 0, both_high = 0;
  int          a_acks = 0, a_errs = 0, v_acks = 0;
  logic [1:0]  rise_wtbt;
  logic [15:0] ack_dout;
  logic [7:0]  glog[$];

  task automatic ctl_step();
    int mode;
    case (ctl_phase)
      0: begin
        mem_ready = 1;
        if (s_strobe) begin
          mode = (ctl_cfg_mode == 0) ? (($urandom_range(0, 9) == 0) ? 2 : 1) : ctl_cfg_mode;
          if (mode == 2) ctl_phase = 4;
          else begin
            mem_ready = 0;
            ctl_left  = (ctl_cfg_mode == 0) ? int'($urandom_range(1, 8)) : ctl_cfg_hold;
            ctl_phase = (mode == 3) ? 3 : 1;
          end
        end
      end
      1: begin
        ctl_left--;
        if (ctl_left == 0) begin
          mem_ready = 1;
          mem_dout  = ctl_data_fixed ? ctl_data : 16'($urandom);
          ctl_phase = 2;
        end
      end
      3: if (ctl_release) begin ctl_release = 0; mem_ready = 1; ctl_phase = 0; end
      default: if (!s_strobe) ctl_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk_sdram);
    s_strobe = mem_rd | mem_we; s_we = mem_we; s_rd = mem_rd;
    s_aack = a_ack; s_aerr = a_err; s_vack = v_ack; s_busy = busy;
    if (s_strobe && !p_strobe) begin
      rises++; rise_wtbt = mem_wtbt;
      glog.push_back((mem_addr == v_addr) ? 8'h56 : 8'h41);
    end
    if (s_strobe) cur_len++;
    else if (p_strobe) begin last_len = cur_len; cur_len = 0; end
    if (s_we) we_cycles++;
    if (s_we && s_rd) both_high++;
    if (s_aack) ack_dout = a_dout;
    p_strobe = s_strobe;
    @(posedge clk_sdram); #1;
    ctl_step();
    if (s_aack) a_acks++;
    if (s_aerr) a_errs++;
    if (s_vack) v_acks++;
    if ((s_aack || s_aerr) && !a_hold) a_req = 0;
    if (s_vack && !v_hold) v_req = 0;
  endtask

  task automatic cpu_issue(input logic we, input logic [23:0] addr, input logic [15:0] din,
                           input logic [1:0] wtbt);
    a_we = we; a_addr = addr; a_din = din; a_wtbt = wtbt; a_req = 1;
  endtask

  task automatic wait_cpu_done(input int budget, input string name);
    int base;
    base = a_acks + a_errs;
    for (int i = 0; i < budget && (a_acks + a_errs) == base; i++) tick();
    check(name, ((a_acks + a_errs) != base) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we0, ack0, err0, r0, vb, ab;
    string exp_seq;
    repeat (3) tick();
    init = 0;
    check("reset_busy", busy, 0);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_a_dout", a_dout, 0);
    check("reset_v_dout", v_dout, 0);
    tick();

    // CPU write, ready low for 6 cycles
    ctl_cfg_mode = 1; ctl_cfg_hold = 6;
    we0 = we_cycles; ack0 = a_acks;
    cpu_issue(1, 24'h000123, 16'hBEEF, 2'b01);
    wait_cpu_done(50, "write_done");
    check("write_strobe_len", last_len, 8);
    check("write_we_cycles", we_cycles - we0, 8);
    check("write_wtbt", rise_wtbt, 2'b01);
    check("write_acks", a_acks - ack0, 1);
    check("write_dout_kept", a_dout, 16'h0000);
    check("write_busy_on_ack", s_busy, 1);
    check("write_busy_after", busy, 0);
    check("model_busy_after", e_busy, 0);

    // CPU read returning 1234
    ctl_cfg_hold = 3; ctl_data_fixed = 1; ctl_data = 16'h1234;
    we0 = we_cycles;
    cpu_issue(0, 24'h00ABCD, 16'h0000, 2'b00);
    wait_cpu_done(50, "read_done");
    check("read_ack_dout", ack_dout, 16'h1234);
    check("model_read_dout", e_a_dout, 16'h1234);
    check("read_wtbt", rise_wtbt, 2'b11);
    check("read_no_we", we_cycles - we0, 0);

    // Both ports held: four video grants then one CPU grant
    ctl_cfg_hold = 2; glog.delete();
    vb = v_acks; ab = a_acks;
    a_hold = 1; v_hold = 1; v_addr = 24'h800077;
    cpu_issue(0, 24'h000055, 16'h0000, 2'b00);
    v_req = 1;
    for (int i = 0; i < 400 && (v_acks - vb + a_acks - ab) < 10; i++) tick();
    a_hold = 0; v_hold = 0; a_req = 0; v_req = 0;
    repeat (3) tick();
    exp_seq = "VVVVAVVVVA";
    check("seq_len", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++) check("grant_seq", glog[i], exp_seq[i]);
    check("seq_v_acks", v_acks - vb, 8);
    check("seq_a_acks", a_acks - ab, 2);

    // Controller never drops ready
    ctl_cfg_mode = 2; ack0 = a_acks; err0 = a_errs;
    cpu_issue(0, 24'h000300, 16'h0000, 2'b00);
    wait_cpu_done(50, "nodrop_done");
    check("nodrop_strobe_len", last_len, DROP_WAIT);
    check("nodrop_errs", a_errs - err0, 1);
    check("nodrop_acks", a_acks - ack0, 0);

    // Controller drops ready and never raises it
    ctl_cfg_mode = 3; err0 = a_errs;
    cpu_issue(1, 24'h000200, 16'h5A5A, 2'b10);
    wait_cpu_done(400, "timeout_done");
    check("timeout_strobe_len", last_len, TIMEOUT + 2);
    check("timeout_errs", a_errs - err0, 1);
    r0 = rises;
    cpu_issue(0, 24'h000201, 16'h0000, 2'b00);
    repeat (6) tick();
    check("no_grant_ready_low", rises - r0, 0);
    ctl_cfg_mode = 1; ctl_cfg_hold = 2; ctl_data = 16'hCAFE; ctl_release = 1;
    wait_cpu_done(50, "after_timeout_done");
    check("after_timeout_dout", ack_dout, 16'hCAFE);

    // init asserted while waiting for ready to return
    ctl_cfg_mode = 3; ack0 = a_acks;
    cpu_issue(0, 24'h000400, 16'h0000, 2'b00);
    repeat (6) tick();
    check("pre_reset_rd", mem_rd, 1);
    #2 init = 1;
    #1;
    check("async_rd_drop", mem_rd, 0);
    check("async_busy_drop", busy, 0);
    repeat (2) tick();
    init = 0;
    r0 = rises;
    repeat (5) tick();
    check("post_reset_no_grant", rises - r0, 0);
    check("post_reset_no_ack", a_acks - ack0, 0);
    ctl_cfg_mode = 1; ctl_data = 16'h0F0F; ctl_release = 1;
    wait_cpu_done(50, "post_reset_done");
    check("post_reset_dout", ack_dout, 16'h0F0F);

    // Random traffic
    ctl_cfg_mode = 0; ctl_data_fixed = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (!a_req && $urandom_range(0, 3) == 0)
        cpu_issue(1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      if (!v_req && $urandom_range(0, 2) == 0) begin
        v_addr = 24'($urandom); v_req = 1;
      end
    end
    ctl_cfg_mode = 1; ctl_cfg_hold = 3;
    for (int i = 0; i < 600 && (a_req || v_req || busy); i++) tick();
    check("drained", {a_req, v_req, busy}, 3'b000);
    check("one_strobe", both_high, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
